// File: rtl/hangman_pkg.sv
// Shared letter encoding, game status type and letter helpers for the hangman engine.
// The optional hint feature is enabled by defining HANGMAN_HINT_EN.
package hangman_pkg;

    localparam int          LETTER_W = 6;
    localparam int          NUM_LETTERS = 26;
    localparam logic [5:0]  DASH     = 6'h00;
    localparam logic [5:0]  LETTER_A = 6'h0A;
    localparam logic [5:0]  LETTER_Z = 6'h23;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        LOSE = 2'd1,
        WIN  = 2'd2,
        IDLE = 2'd3
    } game_status_t;

    function automatic logic is_letter(input logic [LETTER_W-1:0] code);
        return (code >= LETTER_A) && (code <= LETTER_Z);
    endfunction

    // Bitmap index: A maps to bit 0, Z to bit 25.
    function automatic logic [4:0] letter_idx(input logic [LETTER_W-1:0] code);
        logic [LETTER_W-1:0] d;
        d = code - LETTER_A;
        return d[4:0];
    endfunction

endpackage

// File: rtl/hangman_engine_key_strobe.sv
// Guess-key conditioner: two-flop synchroniser on the raw active-low key
// followed by a falling-edge detector producing a single-cycle strobe.
module hangman_engine_key_strobe (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_strobe
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Flops reset to the released level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_strobe = r_prev & ~r_sync;

endmodule

// File: rtl/hangman_engine.sv
// Hangman game engine: secret word store, guess evaluation, reveal mask and game FSM.
// Define HANGMAN_HINT_EN to add the hint_req/hint_used hint feature.
module hangman_engine
    import hangman_pkg::*;
#(
    parameter int WORD_LEN     = 4,
    parameter int MAX_WRONG    = 4,
    parameter int FIRST_REVEAL = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         word_load,
    input  logic [WORD_LEN*LETTER_W-1:0] word_in,
    input  logic                         go_n,
    input  logic [LETTER_W-1:0]          guess,
`ifdef HANGMAN_HINT_EN
    input  logic                         hint_req,
    output logic                         hint_used,
`endif
    output logic [WORD_LEN*LETTER_W-1:0] display,
    output logic [WORD_LEN-1:0]          revealed,
    output logic [2:0]                   wrong_count,
    output logic                         hit,
    output logic                         miss,
    output logic                         repeat_guess,
    output logic [1:0]                   game_status
);

    localparam logic [2:0]          MW       = 3'(MAX_WRONG);
    localparam logic [WORD_LEN-1:0] ALL_REV  = {WORD_LEN{1'b1}};
    localparam logic [WORD_LEN-1:0] LOAD_REV =
        {{(WORD_LEN-1){1'b0}}, (FIRST_REVEAL != 0)};

    game_status_t r_state, w_state_nxt;

    logic [WORD_LEN*LETTER_W-1:0] r_word, w_word_nxt;
    logic [WORD_LEN-1:0]          r_rev, w_rev_nxt;
    logic [NUM_LETTERS-1:0]       r_tried, w_tried_nxt;
    logic [2:0]                   r_wrong, w_wrong_nxt;
    logic                         r_hit, w_hit_nxt;
    logic                         r_miss, w_miss_nxt;
    logic                         r_rep, w_rep_nxt;

    logic                         w_strobe;
    logic [WORD_LEN-1:0]          w_match;
    logic [2:0]                   w_wrong_inc;
    logic [4:0]                   w_gidx;

    hangman_engine_key_strobe u_key (
        .i_clk    (clk),
        .i_rst_n  (resetn),
        .i_key_n  (go_n),
        .o_strobe (w_strobe)
    );

    assign w_wrong_inc = r_wrong + 3'd1;
    assign w_gidx      = letter_idx(guess);

    always_comb begin
        w_match = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            w_match[i] = (r_word[LETTER_W*i +: LETTER_W] == guess);
        end
    end

`ifdef HANGMAN_HINT_EN
    logic                r_hint, w_hint_nxt;
    logic [LETTER_W-1:0] w_hint_letter;
    logic [WORD_LEN-1:0] w_hint_match;
    logic [4:0]          w_hint_idx;
    logic                w_hint_ok;

    // Descending scan leaves the lowest-index hidden letter selected.
    always_comb begin
        w_hint_letter = DASH;
        for (int i = WORD_LEN - 1; i >= 0; i--) begin
            if (!r_rev[i]) begin
                w_hint_letter = r_word[LETTER_W*i +: LETTER_W];
            end
        end
        w_hint_match = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            w_hint_match[i] = (r_word[LETTER_W*i +: LETTER_W] == w_hint_letter);
        end
    end

    assign w_hint_idx = letter_idx(w_hint_letter);
    assign w_hint_ok  = (r_wrong < MW - 3'd1);
    assign hint_used  = r_hint;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_rev_nxt   = r_rev;
        w_tried_nxt = r_tried;
        w_wrong_nxt = r_wrong;
        w_hit_nxt   = r_hit;
        w_miss_nxt  = r_miss;
        w_rep_nxt   = r_rep;
`ifdef HANGMAN_HINT_EN
        w_hint_nxt  = r_hint;
`endif
        if (word_load) begin
            w_state_nxt = PLAY;
            w_word_nxt  = word_in;
            w_rev_nxt   = LOAD_REV;
            w_tried_nxt = '0;
            w_wrong_nxt = '0;
            w_hit_nxt   = 1'b0;
            w_miss_nxt  = 1'b0;
            w_rep_nxt   = 1'b0;
`ifdef HANGMAN_HINT_EN
            w_hint_nxt  = 1'b0;
`endif
        end else if (w_strobe && r_state == PLAY) begin
`ifdef HANGMAN_HINT_EN
            if (hint_req) begin
                if (w_hint_ok) begin
                    w_rev_nxt   = r_rev | w_hint_match;
                    if (is_letter(w_hint_letter)) begin
                        w_tried_nxt[w_hint_idx] = 1'b1;
                    end
                    w_wrong_nxt = w_wrong_inc;
                    w_hint_nxt  = 1'b1;
                    w_hit_nxt   = 1'b0;
                    w_miss_nxt  = 1'b0;
                    w_rep_nxt   = 1'b0;
                    if ((r_rev | w_hint_match) == ALL_REV) begin
                        w_state_nxt = WIN;
                    end
                end else begin
                    w_hint_nxt = 1'b0;
                end
            end else
`endif
            begin
`ifdef HANGMAN_HINT_EN
                w_hint_nxt = 1'b0;
`endif
                w_hit_nxt  = 1'b0;
                w_miss_nxt = 1'b0;
                w_rep_nxt  = 1'b0;
                if (!is_letter(guess)) begin
                    w_rep_nxt = 1'b0;
                end else if (r_tried[w_gidx]) begin
                    w_rep_nxt = 1'b1;
                end else begin
                    w_tried_nxt[w_gidx] = 1'b1;
                    if (|w_match) begin
                        w_rev_nxt = r_rev | w_match;
                        w_hit_nxt = 1'b1;
                        if ((r_rev | w_match) == ALL_REV) begin
                            w_state_nxt = WIN;
                        end
                    end else begin
                        w_wrong_nxt = w_wrong_inc;
                        w_miss_nxt  = 1'b1;
                        if (w_wrong_inc >= MW) begin
                            w_wrong_nxt = MW;
                            w_state_nxt = LOSE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_word  <= '0;
            r_rev   <= '0;
            r_tried <= '0;
            r_wrong <= '0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_rep   <= 1'b0;
`ifdef HANGMAN_HINT_EN
            r_hint  <= 1'b0;
`endif
        end else begin
            r_word  <= w_word_nxt;
            r_rev   <= w_rev_nxt;
            r_tried <= w_tried_nxt;
            r_wrong <= w_wrong_nxt;
            r_hit   <= w_hit_nxt;
            r_miss  <= w_miss_nxt;
            r_rep   <= w_rep_nxt;
`ifdef HANGMAN_HINT_EN
            r_hint  <= w_hint_nxt;
`endif
        end
    end

    // Finished games show the whole word regardless of the reveal mask.
    always_comb begin
        display = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (r_rev[i] || r_state == WIN || r_state == LOSE) begin
                display[LETTER_W*i +: LETTER_W] = r_word[LETTER_W*i +: LETTER_W];
            end else begin
                display[LETTER_W*i +: LETTER_W] = DASH;
            end
        end
    end

    assign revealed     = r_rev;
    assign wrong_count  = r_wrong;
    assign hit          = r_hit;
    assign miss         = r_miss;
    assign repeat_guess = r_rep;
    assign game_status  = r_state;

endmodule

// File: tb/tb_hangman_engine.sv
// Directed bench for hangman_engine with word STAY and a duplicate-letter word.
// Hint steps run only when HANGMAN_HINT_EN is defined.
module tb_hangman_engine;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        word_load = 1'b0;
    logic [23:0] word_in = '0;
    logic        go_n = 1'b1;
    logic [5:0]  guess = '0;
    logic [23:0] display;
    logic [3:0]  revealed;
    logic [2:0]  wrong_count;
    logic        hit;
    logic        miss;
    logic        repeat_guess;
    logic [1:0]  game_status;
`ifdef HANGMAN_HINT_EN
    logic        hint_req = 1'b0;
    logic        hint_used;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [23:0] STAY     = {6'h22, 6'h0A, 6'h1D, 6'h1C};
    localparam logic [23:0] STAY_DSP = 24'h88A75C;
    localparam logic [23:0] DUP      = {6'h0D, 6'h0E, 6'h0E, 6'h0D};

    always #5 clk = ~clk;

    hangman_engine #(
        .WORD_LEN     (4),
        .MAX_WRONG    (4),
        .FIRST_REVEAL (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .word_load    (word_load),
        .word_in      (word_in),
        .go_n         (go_n),
        .guess        (guess),
`ifdef HANGMAN_HINT_EN
        .hint_req     (hint_req),
        .hint_used    (hint_used),
`endif
        .display      (display),
        .revealed     (revealed),
        .wrong_count  (wrong_count),
        .hit          (hit),
        .miss         (miss),
        .repeat_guess (repeat_guess),
        .game_status  (game_status)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [23:0] w);
        @(negedge clk);
        word_in   = w;
        word_load = 1'b1;
        @(negedge clk);
        word_load = 1'b0;
    endtask

    task automatic press(input logic [5:0] g, input int hold);
        @(negedge clk);
        guess = g;
        go_n  = 1'b0;
        repeat (hold) @(negedge clk);
        go_n  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_status", 32'(game_status), 32'd3);
        check("rst_rev", 32'(revealed), 32'h0);
        check("rst_disp", 32'(display), 32'h0);
        check("rst_wrong", 32'(wrong_count), 32'd0);
        check("rst_flags", {29'd0, hit, miss, repeat_guess}, 32'd0);
        resetn = 1'b1;
        press(6'h1C, 5);
        check("idle_ignore", 32'(game_status), 32'd3);
        check("idle_rev", 32'(revealed), 32'h0);

        load(STAY);
        check("ld_status", 32'(game_status), 32'd0);
        check("ld_rev", 32'(revealed), 32'h1);
        check("ld_disp", 32'(display), 32'h00001C);
        check("ld_wrong", 32'(wrong_count), 32'd0);

        press(6'h1D, 5);
        check("g1D_hit", 32'(hit), 32'd1);
        check("g1D_rev", 32'(revealed), 32'h3);
        press(6'h0A, 5);
        check("g0A_rev", 32'(revealed), 32'h7);
        check("g0A_stat", 32'(game_status), 32'd0);
        press(6'h22, 5);
        check("g22_rev", 32'(revealed), 32'hF);
        check("win", 32'(game_status), 32'd2);
        check("win_disp", 32'(display), 32'(STAY_DSP));
        press(6'h0B, 5);
        check("win_hold", 32'(game_status), 32'd2);
        check("win_flags", {30'd0, hit, miss}, 32'd2);

        load(STAY);
        press(6'h0B, 5);
        check("m1_miss", 32'(miss), 32'd1);
        check("m1_wrong", 32'(wrong_count), 32'd1);
        check("m1_disp", 32'(display), 32'h00001C);
        press(6'h0C, 5);
        check("m2_wrong", 32'(wrong_count), 32'd2);
        press(6'h0E, 5);
        check("m3_wrong", 32'(wrong_count), 32'd3);
        check("m3_stat", 32'(game_status), 32'd0);
        press(6'h0F, 5);
        check("m4_wrong", 32'(wrong_count), 32'd4);
        check("lose", 32'(game_status), 32'd1);
        check("lose_disp", 32'(display), 32'(STAY_DSP));
        press(6'h1D, 5);
        check("lose_hold", 32'(game_status), 32'd1);
        check("lose_wrong", 32'(wrong_count), 32'd4);

        load(STAY);
        press(6'h0A, 5);
        check("r1_hit", 32'(hit), 32'd1);
        check("r1_rev", 32'(revealed), 32'h5);
        press(6'h0A, 5);
        check("r2_rep", 32'(repeat_guess), 32'd1);
        check("r2_hit", 32'(hit), 32'd0);
        check("r2_wrong", 32'(wrong_count), 32'd0);
        press(6'h1C, 5);
        check("pre_hit", 32'(hit), 32'd1);
        check("pre_rep", 32'(repeat_guess), 32'd0);
        check("pre_wrong", 32'(wrong_count), 32'd0);
        press(6'h3F, 5);
        check("oor_flags", {29'd0, hit, miss, repeat_guess}, 32'd0);
        check("oor_rev", 32'(revealed), 32'h5);
        check("oor_stat", 32'(game_status), 32'd0);

        load(DUP);
        check("dup_ld", 32'(revealed), 32'h1);
        press(6'h0E, 100);
        check("dup_rev", 32'(revealed), 32'h7);
        check("dup_rep", 32'(repeat_guess), 32'd0);
        check("dup_hit", 32'(hit), 32'd1);

        press(6'h0B, 5);
        check("pre_rst_wrong", 32'(wrong_count), 32'd1);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_stat", 32'(game_status), 32'd3);
        check("arst_disp", 32'(display), 32'h0);
        check("arst_wrong", 32'(wrong_count), 32'd0);
        check("arst_rev", 32'(revealed), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

`ifdef HANGMAN_HINT_EN
        load(STAY);
        hint_req = 1'b1;
        press(6'h00, 5);
        hint_req = 1'b0;
        check("hint_rev", 32'(revealed), 32'h3);
        check("hint_wrong", 32'(wrong_count), 32'd1);
        check("hint_used", 32'(hint_used), 32'd1);
        press(6'h1D, 5);
        check("hint_tried", 32'(repeat_guess), 32'd1);
        press(6'h0B, 5);
        press(6'h0C, 5);
        check("hint_w3", 32'(wrong_count), 32'd3);
        hint_req = 1'b1;
        press(6'h00, 5);
        hint_req = 1'b0;
        check("hint_ref", 32'(hint_used), 32'd0);
        check("hint_ref_w", 32'(wrong_count), 32'd3);
        check("hint_ref_r", 32'(revealed), 32'h3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
